// File: rtl/iob_reg_file_arb_pkg.sv
// Shared FSM encodings and sizing helpers for the iob_reg_file round-robin arbiter.
package iob_reg_file_arb_pkg;

  localparam logic [1:0] StInit  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StClear = 2'd3;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_reg_file.sv
// Column-write register file with registered, write-first read and synchronous bulk clear.
module iob_reg_file #(
  parameter int unsigned NUM_COL    = 2,
  parameter int unsigned COL_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [NUM_COL-1:0]    en,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] new_word;

  always_comb begin
    new_word = mem[addr];
    for (int c = 0; c < NUM_COL; c++) begin
      if (en[c]) new_word[c*COL_WIDTH +: COL_WIDTH] = wdata[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (|en) mem[addr] <= new_word;
      rdata <= new_word;
    end
  end

endmodule

// File: rtl/iob_rr_arbiter.sv
// One-hot grant from a request vector, searching upward from ptr with wrap.
// IOB_REG_FILE_ARB_PRIO_EN selects fixed lowest-index priority instead.
module iob_rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef IOB_REG_FILE_ARB_PRIO_EN
      cand = i;
`else
      cand = (int'(ptr) + i) % N_REQ;
`endif
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = PTR_W'(cand);
      end
    end
  end

`ifdef IOB_REG_FILE_ARB_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/iob_reg_file_arb.sv
// Shares one iob_reg_file port among N_REQ requesters and sequences whole-file clears.
// Define IOB_REG_FILE_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module iob_reg_file_arb
  import iob_reg_file_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned NUM_COL    = 2,
  parameter int unsigned COL_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [N_REQ*NUM_COL-1:0]    req_wstrb,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  input  logic                        clr_req,
  output logic                        clr_done,
  output logic                        rf_rst,
  output logic [ADDR_WIDTH-1:0]       rf_addr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  output logic [NUM_COL-1:0]          rf_en,
  input  logic [DATA_WIDTH-1:0]       rf_rdata
);

  localparam int unsigned PtrW = ptr_width(N_REQ);

  logic [1:0]            state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d, gnt_idx;
  logic [N_REQ-1:0]      arb_req, gnt, rsp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  accept;

  // A pending clear outranks any request in the same cycle.
  assign arb_req = (rst && state_q == StRun && !clr_req) ? req_valid : '0;

  iob_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PtrW)
  ) u_arb (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept    = |gnt;
  assign req_ready = gnt;

  always_comb begin
    rf_addr  = rst ? addr_q : '0;
    rf_wdata = '0;
    rf_en    = '0;
    if (accept) begin
      rf_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      rf_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      rf_en    = req_wstrb[gnt_idx*NUM_COL +: NUM_COL];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit:  state_d = StRun;
      StRun: begin
        if (clr_req) begin
          state_d = StDrain;
        end else if (accept) begin
`ifndef IOB_REG_FILE_ARB_PRIO_EN
          ptr_d = (gnt_idx == PtrW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
      end
      StDrain: if (rsp_q == '0) state_d = StClear;
      StClear: state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
      rsp_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rsp_q   <= gnt;
      if (accept) addr_q <= rf_addr;
    end
  end

  // Outputs are forced to their reset values while rst is low, dropping any in-flight response.
  assign rsp_valid = rst ? rsp_q : '0;
  assign rsp_rdata = (rst && |rsp_q) ? rf_rdata : '0;
  assign clr_done  = rst && (state_q == StClear);
  assign rf_rst    = !rst || (state_q == StInit) || (state_q == StClear);

endmodule

// File: tb/tb_iob_reg_file_arb.sv
// Directed self-checking bench: arbiter plus a real iob_reg_file behind it.
module tb_iob_reg_file_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_addr;
  logic [15:0] req_wdata;
  logic [3:0] req_wstrb;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic       clr_req, clr_done, rf_rst;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata, rf_rdata;
  logic [1:0] rf_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iob_reg_file_arb #(
    .N_REQ      (2),
    .NUM_COL    (2),
    .COL_WIDTH  (4),
    .ADDR_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clr_req   (clr_req),
    .clr_done  (clr_done),
    .rf_rst    (rf_rst),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .rf_en     (rf_en),
    .rf_rdata  (rf_rdata)
  );

  iob_reg_file #(
    .NUM_COL    (2),
    .COL_WIDTH  (4),
    .ADDR_WIDTH (4)
  ) u_rf (
    .clk   (clk),
    .rst   (rf_rst),
    .addr  (rf_addr),
    .wdata (rf_wdata),
    .en    (rf_en),
    .rdata (rf_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts and ends at posedge+1; one access from requester k, response checked next cycle.
  task automatic access(input int k, input logic [3:0] a, input logic [7:0] d,
                        input logic [1:0] s, input logic [7:0] exp, input bit chk);
    int waited = 0;
    logic [1:0] onehot;
    onehot = 2'b01 << k;
    req_valid = onehot;
    req_addr[k*4 +: 4]  = a;
    req_wdata[k*8 +: 8] = d;
    req_wstrb[k*2 +: 2] = s;
    #3;
    while (req_ready[k] !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #3;
      waited++;
    end
    check_val("accept_in_time", 32'(waited < 20), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    #3;
    check_val("rsp_valid_1cyc", 32'(rsp_valid), 32'(onehot));
    if (chk) check_val("rsp_rdata", 32'(rsp_rdata), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input int k);
    for (int i = 0; i < 16; i++) access(k, 4'(i), 8'h00, 2'b00, 8'h00, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g, prev_g;
    int         n_acc;
    bit         seen;

    rst = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    check_val("rst_rf_rst", 32'(rf_rst), 32'd1);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_val("rst_clr_done", 32'(clr_done), 32'd0);
    check_val("rst_rf_en", 32'(rf_en), 32'd0);
    check_val("rst_rf_addr", 32'(rf_addr), 32'd0);
    check_val("rst_rf_wdata", 32'(rf_wdata), 32'd0);

    // 1: release reset, one INIT cycle with no grant
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b01;
    #3;
    check_val("init_rf_rst", 32'(rf_rst), 32'd1);
    check_val("init_no_grant", 32'(req_ready), 32'd0);
    check_val("init_no_clr_done", 32'(clr_done), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    #3;
    check_val("run_rf_rst_low", 32'(rf_rst), 32'd0);
    @(posedge clk); #1;
    read_all_zero(0);

    // 2: req0 fills the file, req1 reads it back
    for (int i = 0; i < 16; i++) access(0, 4'(i), 8'(i), 2'b11, 8'(i), 1'b1);
    for (int i = 0; i < 16; i++) access(1, 4'(i), 8'h00, 2'b00, 8'(i), 1'b1);

    // 3: both requesting every cycle
    req_valid = 2'b11;
    req_addr  = 8'h10;
    req_wstrb = '0;
    n_acc = 0;
    prev_g = '0;
    for (int j = 0; j < 8; j++) begin
      #3;
`ifdef IOB_REG_FILE_ARB_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
`endif
      check_val("rr_grant", 32'(req_ready), 32'(exp_g));
      if (j > 0) check_val("rr_rsp_valid", 32'(rsp_valid), 32'(prev_g));
      if (req_ready != 2'b00) n_acc++;
      prev_g = exp_g;
      @(posedge clk); #1;
    end
    req_valid = '0;
    #3;
    check_val("rr_last_rsp", 32'(rsp_valid), 32'(prev_g));
    check_val("rr_accepts", 32'(n_acc), 32'd8);
    @(posedge clk); #1;

    // 4: column writes
    access(0, 4'd3, 8'h33, 2'b11, 8'h33, 1'b1);
    access(0, 4'd3, 8'hA5, 2'b01, 8'h35, 1'b1);
    access(1, 4'd3, 8'h00, 2'b00, 8'h35, 1'b1);
    access(0, 4'd3, 8'hC0, 2'b10, 8'hC5, 1'b1);
    access(1, 4'd3, 8'h00, 2'b00, 8'hC5, 1'b1);
    check_val("idle_rf_en", 32'(rf_en), 32'd0);
    check_val("idle_rf_addr_hold", 32'(rf_addr), 32'd3);

    // 5: clear requested while a read is in flight
    req_valid = 2'b01;
    req_addr[3:0] = 4'd3;
    req_wstrb = '0;
    #3;
    check_val("clr_pre_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    clr_req = 1'b1;
    req_valid = 2'b11;
    #3;
    check_val("clr_inflight_valid", 32'(rsp_valid), 32'd1);
    check_val("clr_inflight_data", 32'(rsp_rdata), 32'hC5);
    check_val("clr_wins", 32'(req_ready), 32'd0);
    seen = 1'b0;
    for (int j = 0; j < 8 && !seen; j++) begin
      @(posedge clk); #3;
      check_val("clr_no_grant", 32'(req_ready), 32'd0);
      if (clr_done) begin
        seen = 1'b1;
        check_val("clr_rf_rst", 32'(rf_rst), 32'd1);
      end
    end
    check_val("clr_done_seen", 32'(seen), 32'd1);
    clr_req = 1'b0;
    req_valid = '0;
    @(posedge clk); #3;
    check_val("clr_done_pulse", 32'(clr_done), 32'd0);
    check_val("clr_rf_rst_low", 32'(rf_rst), 32'd0);
    @(posedge clk); #1;
    read_all_zero(1);

    // 6: reset with a response pending
    access(0, 4'd5, 8'h77, 2'b11, 8'h77, 1'b1);
    req_valid = 2'b01;
    req_addr[3:0] = 4'd6;
    req_wdata[7:0] = 8'h66;
    req_wstrb[1:0] = 2'b11;
    #3;
    check_val("rst6_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b0;
    #3;
    check_val("rst6_rsp_drop", 32'(rsp_valid), 32'd0);
    check_val("rst6_rf_rst", 32'(rf_rst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    check_val("rst6_init_rf_rst", 32'(rf_rst), 32'd1);
    check_val("rst6_rsp_still_0", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    read_all_zero(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
